perm_round_scheduler: RTL and testbench
=======================================

Name: perm_round_scheduler

Overview:
- Top-level sequencer for the line-based permutation datapath.
- On `start`:
  - reads LINES state lines from the input line memory into the line register file;
  - steps the permutation core through LINES lines per round for ROUNDS rounds;
  - writes LINES result lines to the output memory;
  - pulses `done`.
- Sits between the host handshake and the datapath. Owns all memory addressing and round/line indexing.

Parameters:
- LINES, 25, number of lines in the permutation state.
- ROUNDS, 24, number of permutation rounds.
- ADDR_W, 5, line index/address width; must satisfy 2**ADDR_W >= LINES.
- RND_W, 5, round index width; must satisfy 2**RND_W >= ROUNDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a permutation; sampled only in IDLE.
- abort  in  1  synchronous cancel; forces IDLE, no done.
- rd_en  out  1  input-memory read strobe.
- rd_addr  out  ADDR_W  input-memory read address.
- line_load  out  1  load line register `line_idx` with memory data.
- line_idx  out  ADDR_W  destination line for `line_load`.
- perm_en  out  1  permutation core step enable.
- perm_line  out  ADDR_W  line being processed.
- round_idx  out  RND_W  current round, 0..ROUNDS-1.
- wr_en  out  1  output-memory write strobe.
- wr_addr  out  ADDR_W  output-memory write address; also line-register read select.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, `rst`=1): state=IDLE; line_cnt=0, round_cnt=0. All outputs 0, including `line_load` and `line_idx`.
- Output timing:
  - Moore outputs are decoded from state and counters.
  - `line_load` and `line_idx` are registered: they equal `rd_en` and `rd_addr` delayed by one cycle, matching the one-cycle memory read latency.
- IDLE:
  - All strobes 0.
  - start=1 → LOAD, line_cnt←0.
- LOAD:
  - rd_en=1, rd_addr=line_cnt; line_cnt increments each cycle.
  - At line_cnt==LINES-1 → DRAIN, line_cnt←0.
- DRAIN:
  - One cycle, no strobes except the registered `line_load` for line LINES-1.
  - → ROUND, round_cnt←0.
- ROUND:
  - perm_en=1, perm_line=line_cnt, round_idx=round_cnt.
  - line_cnt wraps LINES-1→0 and round_cnt increments on the wrap.
  - At line_cnt==LINES-1 and round_cnt==ROUNDS-1 → WRITE, both counters ←0.
- WRITE:
  - wr_en=1, wr_addr=line_cnt.
  - At LINES-1 → DONE.
- DONE:
  - done=1, busy=1 for exactly one cycle.
  - → IDLE unconditionally.
- Latency: `done` is high in the cycle beginning 2*LINES+1+LINES*ROUNDS edges after the edge that samples `start` (651 with defaults).
- `start` while busy: ignored, no queuing. `start` held high through DONE begins a new run on the cycle after DONE.
- abort=1 in any state: next state IDLE, counters ←0, no `done`. `abort` takes priority over `start`.
- `rst` mid-operation: immediate return to reset values.
- Counters never exceed LINES-1 or ROUNDS-1. No unused-state lockup: illegal state encodings → IDLE.

Decomposition:
- Shared package `perm_pkg`:
  - state encodings IDLE/LOAD/DRAIN/ROUND/WRITE/DONE;
  - default LINES/ROUNDS constants;
  - latency constant 2*LINES+1+LINES*ROUNDS.
- Sub-module `mod_counter`, parameterized by width and modulus, instantiated twice (line_cnt, round_cnt). Ports:
  - clk, rst;
  - clr, en, count;
  - wrap: asserted when en and count==modulus-1.

Test Plan:
- Reset then single start pulse → rd_addr 0..24 over 25 cycles; line_load/line_idx 0..24 one cycle later; perm_en for 600 cycles with round_idx 0..23; wr_addr 0..24; done exactly at edge 651; busy low afterwards.
- Round boundary → at perm_line 24 with round_idx 3, next cycle shows perm_line 0 and round_idx 4; last ROUND cycle shows line 24, round 23, then wr_en=1, wr_addr 0.
- start pulsed at cycles 10 and 300 during a run → ignored; exactly one done, still at edge 651.
- abort asserted at ROUND cycle 100 → next cycle busy=0 and all strobes 0, no done; a fresh start then completes in 651 cycles.
- rst asserted asynchronously mid-WRITE (wr_addr=7) → outputs zero without waiting for a clock edge; next start runs from rd_addr 0.
- start held high continuously → back-to-back runs; done pulses separated by exactly 653 cycles.

Source files
------------

// File: rtl/perm_pkg.sv
// Shared constants and state encoding for the permutation round scheduler.
package perm_pkg;

  localparam int unsigned LINES_DEF  = 25;
  localparam int unsigned ROUNDS_DEF = 24;

  // Edges from the start-sampling edge to the cycle in which done is high.
  localparam int unsigned LATENCY_DEF = 2 * LINES_DEF + 1 + LINES_DEF * ROUNDS_DEF;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StDrain = 3'd2,
    StRound = 3'd3,
    StWrite = 3'd4,
    StDone  = 3'd5
  } perm_state_e;

  function automatic int unsigned perm_latency(input int unsigned lines,
                                               input int unsigned rounds);
    return 2 * lines + 1 + lines * rounds;
  endfunction

endpackage

// File: rtl/perm_round_scheduler_mod_counter.sv
// Modulo counter with synchronous clear and a wrap flag on the terminal count.
module mod_counter #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned MODULUS = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);

  assign wrap = en && (count == MaxCount);

  // Count register: clear wins over enable; wraps to zero after MODULUS-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/perm_round_scheduler.sv
// Sequencer: load state lines, run ROUNDS x LINES permutation steps, write
// results back, then pulse done.
module perm_round_scheduler
  import perm_pkg::*;
#(
  parameter int unsigned LINES  = LINES_DEF,
  parameter int unsigned ROUNDS = ROUNDS_DEF,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned RND_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              line_load,
  output logic [ADDR_W-1:0] line_idx,
  output logic              perm_en,
  output logic [ADDR_W-1:0] perm_line,
  output logic [RND_W-1:0]  round_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done
);

  perm_state_e state_q, state_d;

  logic [ADDR_W-1:0] line_cnt;
  logic [RND_W-1:0]  round_cnt;
  logic              line_clr, line_en, line_wrap;
  logic              round_clr, round_en, round_wrap;

  mod_counter #(
    .WIDTH   (ADDR_W),
    .MODULUS (LINES)
  ) u_line_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (line_clr),
    .en    (line_en),
    .count (line_cnt),
    .wrap  (line_wrap)
  );

  mod_counter #(
    .WIDTH   (RND_W),
    .MODULUS (ROUNDS)
  ) u_round_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (round_clr),
    .en    (round_en),
    .count (round_cnt),
    .wrap  (round_wrap)
  );

  // Round counter advances only when the line counter wraps inside ROUND.
  assign round_en = (state_q == StRound) && line_wrap;

  // Counter control: line counter runs in the three streaming phases, round
  // counter only in ROUND; both are held at zero elsewhere and on abort.
  always_comb begin
    line_en   = 1'b0;
    line_clr  = 1'b1;
    round_clr = 1'b1;
    unique case (state_q)
      StLoad, StWrite: begin
        line_en  = 1'b1;
        line_clr = 1'b0;
      end
      StRound: begin
        line_en   = 1'b1;
        line_clr  = 1'b0;
        round_clr = 1'b0;
      end
      default: ;
    endcase
    if (abort) begin
      line_clr  = 1'b1;
      round_clr = 1'b1;
    end
  end

  // Next-state logic; abort overrides everything, unknown encodings recover.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  if (line_wrap) state_d = StDrain;
      StDrain: state_d = StRound;
      StRound: if (line_wrap && round_wrap) state_d = StWrite;
      StWrite: if (line_wrap) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode; addresses are forced to zero outside their phase.
  always_comb begin
    rd_en     = 1'b0;
    rd_addr   = '0;
    perm_en   = 1'b0;
    perm_line = '0;
    round_idx = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      StLoad: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = line_cnt;
      end
      StDrain: busy = 1'b1;
      StRound: begin
        busy      = 1'b1;
        perm_en   = 1'b1;
        perm_line = line_cnt;
        round_idx = round_cnt;
      end
      StWrite: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = line_cnt;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Line-register load follows the read strobe by the memory's one-cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_load <= 1'b0;
      line_idx  <= '0;
    end else begin
      line_load <= rd_en;
      line_idx  <= rd_addr;
    end
  end

endmodule

// File: tb/tb_perm_round_scheduler.sv
// Self-checking bench for perm_round_scheduler: a cycle-offset model checked
// every cycle plus directed scenarios with hand-computed expectations.
module tb_perm_round_scheduler;

  localparam int L   = 25;
  localparam int R   = 24;
  localparam int LAT = 2 * L + 1 + L * R;  // 651
  localparam int RS  = L + 1;              // first ROUND offset
  localparam int WS  = L + 1 + L * R;      // first WRITE offset

  logic       clk, rst, start, abort;
  logic       rd_en, line_load, perm_en, wr_en, busy, done;
  logic [4:0] rd_addr, line_idx, perm_line, round_idx, wr_addr;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;

  perm_round_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .line_load (line_load),
    .line_idx  (line_idx),
    .perm_en   (perm_en),
    .perm_line (perm_line),
    .round_idx (round_idx),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: mk is the number of cycles since the run began (LOAD = 0), -1 idle.
  function automatic bit e_rd(input int k);
    return k >= 0 && k < L;
  endfunction
  function automatic int e_rd_addr(input int k);
    return e_rd(k) ? k : 0;
  endfunction
  function automatic bit e_perm(input int k);
    return k >= RS && k < WS;
  endfunction
  function automatic bit e_wr(input int k);
    return k >= WS && k < LAT;
  endfunction

  int  mk;
  bit  m_ll;
  int  m_li;

  // Model advance: abort and reset return to idle; a run lasts LAT+1 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mk   <= -1;
      m_ll <= 1'b0;
      m_li <= 0;
    end else begin
      m_ll <= e_rd(mk);
      m_li <= e_rd_addr(mk);
      if (abort)           mk <= -1;
      else if (mk < 0)     mk <= start ? 0 : -1;
      else if (mk == LAT)  mk <= -1;
      else                 mk <= mk + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_rd_en",     rd_en,     e_rd(mk));
    chk("cmp_rd_addr",   rd_addr,   e_rd_addr(mk));
    chk("cmp_line_load", line_load, m_ll);
    chk("cmp_line_idx",  line_idx,  m_li);
    chk("cmp_perm_en",   perm_en,   e_perm(mk));
    chk("cmp_perm_line", perm_line, e_perm(mk) ? (mk - RS) % L : 0);
    chk("cmp_round_idx", round_idx, e_perm(mk) ? (mk - RS) / L : 0);
    chk("cmp_wr_en",     wr_en,     e_wr(mk));
    chk("cmp_wr_addr",   wr_addr,   e_wr(mk) ? mk - WS : 0);
    chk("cmp_busy",      busy,      mk >= 0);
    chk("cmp_done",      done,      mk == LAT);
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},     rd_en,     0);
    chk({tag, "_rd_addr"},   rd_addr,   0);
    chk({tag, "_line_load"}, line_load, 0);
    chk({tag, "_line_idx"},  line_idx,  0);
    chk({tag, "_perm_en"},   perm_en,   0);
    chk({tag, "_wr_en"},     wr_en,     0);
    chk({tag, "_wr_addr"},   wr_addr,   0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
  endtask

  // One run from IDLE; returns done latency and the cycle number of done.
  task automatic run_one(input bit pulse_mid, input bit keep_start,
                         output int lat, output int dcyc);
    int s, k, d0;
    d0    = done_cnt;
    lat   = -1;
    dcyc  = -1;
    start = 1'b1;
    s     = cyc + 1;
    @(negedge clk);
    if (!keep_start) start = 1'b0;
    while (lat < 0 && (cyc - s) < 1000) begin
      k = cyc - s;
      case (k)
        0:   begin chk("lit_rd_en0", rd_en, 1); chk("lit_rd_addr0", rd_addr, 0); end
        1:   begin chk("lit_ll1", line_load, 1); chk("lit_li1", line_idx, 0); end
        24:  chk("lit_rd_addr24", rd_addr, 24);
        25:  begin chk("lit_ll25", line_load, 1); chk("lit_li25", line_idx, 24);
                   chk("lit_rd_en25", rd_en, 0); end
        125: begin chk("lit_pl_125", perm_line, 24); chk("lit_ri_125", round_idx, 3); end
        126: begin chk("lit_pl_126", perm_line, 0); chk("lit_ri_126", round_idx, 4); end
        625: begin chk("lit_pl_625", perm_line, 24); chk("lit_ri_625", round_idx, 23); end
        626: begin chk("lit_wr_en626", wr_en, 1); chk("lit_wr_addr626", wr_addr, 0); end
        default: ;
      endcase
      if (pulse_mid) start = (k == 10 || k == 300);
      if (done === 1'b1) begin
        lat  = k;
        dcyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    chk("latency", lat, 651);
    @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    if (!keep_start) chk("busy_after", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, dcyc, s, d0, gap;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain run.
    run_one(1'b0, 1'b0, lat, dcyc);

    // Start pulses mid-run are ignored.
    run_one(1'b1, 1'b0, lat, dcyc);

    // Abort at ROUND cycle 100.
    start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc - s < RS + 100) @(negedge clk);
    chk("pre_abort_perm_en", perm_en, 1);
    abort = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    abort = 1'b0;
    chk_all_zero("abort");
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    run_one(1'b0, 1'b0, lat, dcyc);

    // Async reset in the middle of WRITE.
    start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc - s < WS + 7) @(negedge clk);
    chk("pre_rst_wr_addr", wr_addr, 7);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_one(1'b0, 1'b0, lat, dcyc);

    // Start held high: back-to-back runs.
    run_one(1'b0, 1'b1, lat, dcyc);
    gap = -1;
    for (int i = 0; i < 1000 && gap < 0; i++) begin
      if (done === 1'b1) gap = cyc - dcyc;
      else @(negedge clk);
    end
    start = 1'b0;
    chk("done_gap", gap, 653);
    repeat (3) @(negedge clk);
    chk("idle_after_b2b", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
